// File: rtl/manchester_tx.sv
`default_nettype none
// ============================================================================
// Module      : manchester_tx
// Description : Manchester (IEEE 802.3) line transmitter. Each frame is an
//               alternating clock-training preamble, a two-bit SFD (1,1),
//               then the data word LSB first. clk runs at twice the bit
//               rate, so every clk cycle is one half-bit.
//               Optional build macro MANCHESTER_TX_PARITY_EN appends one
//               even-parity bit after the data.
// Ports       : clk        half-bit clock (2x bit rate)
//               rst        asynchronous active-high reset
//               tx_data    word to send, sampled only at the handshake
//               tx_valid   word available
//               tx_ready   block can accept a word (state is IDLE)
//               tx_out     registered Manchester line output
//               tx_bit_clk registered bit-rate clock, high in 2nd half-bit
//               tx_busy    registered, high while a frame is on the line
//               tx_done    registered one-cycle pulse after a frame ends
// Revision    : 1.0 - initial release
// ============================================================================
module manchester_tx #(
    parameter int   WIDTH        = 8,
    parameter int   PREAMBLE_LEN = 8,
    parameter logic IDLE_LEVEL   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_out,
    output logic             tx_bit_clk,
    output logic             tx_busy,
    output logic             tx_done
);

    localparam int CNT_MAX = (PREAMBLE_LEN > WIDTH) ? PREAMBLE_LEN : WIDTH;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_LEN - 1);
    localparam logic [CNT_W-1:0] SFD_LAST  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_SFD  = 3'd2,
        S_DATA = 3'd3,
        S_PAR  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic               out_q, out_d;
    logic               bclk_q, bclk_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               line_bit;

`ifdef MANCHESTER_TX_PARITY_EN
    logic               par_q, par_d;
`endif

    assign tx_ready   = (state_q == S_IDLE);
    assign tx_out     = out_q;
    assign tx_bit_clk = bclk_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;

    // Next-state, counters and shift register.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
`ifdef MANCHESTER_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q != S_IDLE) begin
            phase_d = ~phase_q;
            if (phase_q) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                phase_d = 1'b0;
                cnt_d   = '0;
                if (tx_valid) begin
                    state_d = S_PRE;
                    shreg_d = tx_data;
`ifdef MANCHESTER_TX_PARITY_EN
                    par_d   = ^tx_data;
`endif
                end
            end
            S_PRE: begin
                if (phase_q && (cnt_q == PRE_LAST)) begin
                    state_d = S_SFD;
                    cnt_d   = '0;
                end
            end
            S_SFD: begin
                if (phase_q && (cnt_q == SFD_LAST)) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end
            end
            S_DATA: begin
                if (phase_q) begin
                    // Bit 0 of the shift register is always the bit on the line.
                    shreg_d = shreg_q >> 1;
                    if (cnt_q == DATA_LAST) begin
`ifdef MANCHESTER_TX_PARITY_EN
                        state_d = S_PAR;
`else
                        state_d = S_IDLE;
`endif
                        cnt_d   = '0;
                    end
                end
            end
`ifdef MANCHESTER_TX_PARITY_EN
            S_PAR: begin
                if (phase_q) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                phase_d = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state values so the line shows
    // the first preamble half-bit in the cycle right after the handshake.
    always_comb begin
        line_bit = 1'b0;
        case (state_d)
            S_PRE:  line_bit = ~cnt_d[0];  // 1,0,1,0... ending in 0 (even length)
            S_SFD:  line_bit = 1'b1;
            S_DATA: line_bit = shreg_d[0];
`ifdef MANCHESTER_TX_PARITY_EN
            S_PAR:  line_bit = par_d;
`endif
            default: line_bit = 1'b0;
        endcase

        busy_d = (state_d != S_IDLE);
        out_d  = busy_d ? (phase_d ? line_bit : ~line_bit) : IDLE_LEVEL;
        bclk_d = busy_d & phase_d;
        done_d = (state_q != S_IDLE) && (state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            phase_q <= 1'b0;
            cnt_q   <= '0;
            shreg_q <= '0;
            out_q   <= IDLE_LEVEL;
            bclk_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MANCHESTER_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            out_q   <= out_d;
            bclk_q  <= bclk_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef MANCHESTER_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_manchester_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_manchester_tx
// Description : Directed self-checking bench for manchester_tx
//               (WIDTH=8, PREAMBLE_LEN=4, IDLE_LEVEL=0). Honours
//               MANCHESTER_TX_PARITY_EN for the expected frame layout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_manchester_tx;

    localparam int W  = 8;
    localparam int PL = 4;
`ifdef MANCHESTER_TX_PARITY_EN
    localparam int FL = 2 * (PL + 3 + W);
`else
    localparam int FL = 2 * (PL + 2 + W);
`endif

    logic         clk;
    logic         rst;
    logic [W-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         tx_out;
    logic         tx_bit_clk;
    logic         tx_busy;
    logic         tx_done;

    int n_pass  = 0;
    int n_total = 0;

    logic [0:31] e_bclk;

    manchester_tx #(
        .WIDTH        (W),
        .PREAMBLE_LEN (PL),
        .IDLE_LEVEL   (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_out     (tx_out),
        .tx_bit_clk (tx_bit_clk),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected half-bit stream of one frame, first half-bit at index 0.
    function automatic logic [0:31] model(input logic [W-1:0] d);
        logic [0:31] v;
        int          k;
        logic        b;
        v = '0;
        k = 0;
        for (int i = 0; i < PL; i++) begin
            b = (i % 2 == 0);
            v[k] = ~b; v[k+1] = b; k += 2;
        end
        for (int i = 0; i < 2; i++) begin
            v[k] = 1'b0; v[k+1] = 1'b1; k += 2;
        end
        for (int i = 0; i < W; i++) begin
            b = d[i];
            v[k] = ~b; v[k+1] = b; k += 2;
        end
`ifdef MANCHESTER_TX_PARITY_EN
        b = ^d;
        v[k] = ~b; v[k+1] = b;
`endif
        return v;
    endfunction

    task automatic start(input logic [W-1:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    // Samples FL half-bits; optionally drives tx_data/tx_valid mid-frame.
    task automatic capture(input int poke_at, input logic [W-1:0] poke_data,
                           input logic poke_valid, input logic poke_hold,
                           output logic [0:31] ov, output logic [0:31] bv,
                           output int busy_n, output int ready_n, output int done_n);
        ov = '0; bv = '0; busy_n = 0; ready_n = 0; done_n = 0;
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            ov[i] = tx_out;
            bv[i] = tx_bit_clk;
            if (tx_busy)  busy_n++;
            if (tx_ready) ready_n++;
            if (tx_done)  done_n++;
            if (i == poke_at) begin
                tx_data  = poke_data;
                tx_valid = poke_valid;
            end
            if (i == poke_at + 2) tx_valid = poke_hold;
        end
    endtask

    task automatic check_frame(input string name, input logic [0:31] ov, input logic [0:31] ev,
                               input logic [0:31] bv, input int busy_n, input int ready_n,
                               input int done_n);
        n_total++;
        if (ov !== ev) $display("FAIL %s tx_out: got %b expected %b", name, ov, ev);
        else n_pass++;
        n_total++;
        if (bv !== e_bclk) $display("FAIL %s tx_bit_clk: got %b expected %b", name, bv, e_bclk);
        else n_pass++;
        n_total++;
        if (busy_n != FL || ready_n != 0 || done_n != 0)
            $display("FAIL %s busy/ready/done counts: got %0d/%0d/%0d expected %0d/0/0",
                     name, busy_n, ready_n, done_n, FL);
        else n_pass++;
    endtask

    task automatic check_end(input string name, input logic check_after);
        @(negedge clk);
        n_total++;
        if ({tx_done, tx_busy, tx_out, tx_bit_clk, tx_ready} !== 5'b10001)
            $display("FAIL %s end cycle done,busy,out,bclk,ready: got %b expected 10001", name,
                     {tx_done, tx_busy, tx_out, tx_bit_clk, tx_ready});
        else n_pass++;
        if (check_after) begin
            @(negedge clk);
            n_total++;
            if ({tx_done, tx_busy, tx_ready} !== 3'b001)
                $display("FAIL %s after end done,busy,ready: got %b expected 001", name,
                         {tx_done, tx_busy, tx_ready});
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        int bad;
        n_total++;
        if ({tx_ready, tx_out, tx_bit_clk, tx_busy, tx_done} !== 5'b10000)
            $display("FAIL reset_values: got %b expected 10000",
                     {tx_ready, tx_out, tx_bit_clk, tx_busy, tx_done});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ({tx_ready, tx_out, tx_bit_clk, tx_busy, tx_done} !== 5'b10000) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL idle_20: got %0d bad cycles expected 0", bad);
        else n_pass++;
    endtask

    task automatic test_single_a5();
        logic [0:31] ov, bv, ev;
        int bn, rn, dn;
`ifdef MANCHESTER_TX_PARITY_EN
        ev = {28'b0110011001010110011010011001, 2'b10, 2'b00};
`else
        ev = {28'b0110011001010110011010011001, 4'b0000};
`endif
        start(8'hA5);
        capture(-1, '0, 1'b0, 1'b0, ov, bv, bn, rn, dn);
        check_frame("frame_A5", ov, ev, bv, bn, rn, dn);
        check_end("frame_A5", 1'b1);
    endtask

    task automatic test_single_01();
        logic [0:31] ov, bv, ev;
        int bn, rn, dn;
`ifdef MANCHESTER_TX_PARITY_EN
        ev = {28'b0110011001010110101010101010, 2'b01, 2'b00};
`else
        ev = {28'b0110011001010110101010101010, 4'b0000};
`endif
        start(8'h01);
        capture(-1, '0, 1'b0, 1'b0, ov, bv, bn, rn, dn);
        check_frame("frame_01", ov, ev, bv, bn, rn, dn);
        check_end("frame_01", 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [0:31] ov, bv;
        int bn, rn, dn;
        @(negedge clk);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        // Next word presented mid-frame must not disturb the running frame.
        capture(5, 8'h00, 1'b1, 1'b1, ov, bv, bn, rn, dn);
        check_frame("b2b_FF", ov, model(8'hFF), bv, bn, rn, dn);
        n_total++;
        if (ov[12:27] !== 16'h5555) $display("FAIL b2b_FF data halves: got %h expected 5555", ov[12:27]);
        else n_pass++;
        check_end("b2b_gap", 1'b0);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        capture(-1, '0, 1'b0, 1'b0, ov, bv, bn, rn, dn);
        check_frame("b2b_00", ov, model(8'h00), bv, bn, rn, dn);
        n_total++;
        if (ov[12:27] !== 16'hAAAA) $display("FAIL b2b_00 data halves: got %h expected AAAA", ov[12:27]);
        else n_pass++;
        check_end("b2b_00", 1'b1);
    endtask

    task automatic test_async_reset();
        logic [0:31] ov, bv;
        int bn, rn, dn, bad;
        start(8'h5A);
        for (int i = 0; i < 10; i++) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if ({tx_out, tx_busy, tx_ready, tx_bit_clk, tx_done} !== 5'b00100)
            $display("FAIL async_reset out,busy,ready,bclk,done: got %b expected 00100",
                     {tx_out, tx_busy, tx_ready, tx_bit_clk, tx_done});
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tx_done || tx_busy || !tx_ready) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL post_reset_quiet: got %0d active cycles expected 0", bad);
        else n_pass++;
        start(8'h3C);
        capture(-1, '0, 1'b0, 1'b0, ov, bv, bn, rn, dn);
        check_frame("frame_3C", ov, model(8'h3C), bv, bn, rn, dn);
        check_end("frame_3C", 1'b1);
    endtask

    task automatic test_valid_while_busy();
        logic [0:31] ov, bv;
        int bn, rn, dn, bad;
        start(8'hC3);
        capture(6, 8'h99, 1'b1, 1'b0, ov, bv, bn, rn, dn);
        check_frame("busy_C3", ov, model(8'hC3), bv, bn, rn, dn);
        check_end("busy_C3", 1'b0);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (tx_busy || tx_done || !tx_ready) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL busy_no_resend: got %0d active cycles expected 0", bad);
        else n_pass++;
    endtask

    initial begin
        rst      = 1'b1;
        tx_data  = '0;
        tx_valid = 1'b0;
        e_bclk   = '0;
        for (int i = 0; i < FL; i++) e_bclk[i] = (i % 2 == 1);
        #1;
        test_reset();
        test_single_a5();
        test_single_01();
        test_back_to_back();
        test_async_reset();
        test_valid_while_busy();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
